// File: rtl/led_fade_sequencer.sv
// Shared PWM fade engine time-multiplexed across NUM_LEDS outputs.
// The owning LED ramps up, holds fully on, ramps down, then ownership moves on.
module led_fade_sequencer #(
   parameter int NUM_LEDS     = 8,
   parameter int IDX_W        = 3,
   parameter int CW           = 29,
   parameter int PERIOD       = 500000,
   parameter int STEP_SIZE    = 20000,
   parameter int HOLD_PERIODS = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                reverse,
   output logic [NUM_LEDS-1:0] leds,
   output logic [IDX_W-1:0]    active_idx,
   output logic [1:0]          state,
   output logic                period_tick
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      HOLD = 2'd2,
      FALL = 2'd3
   } state_t;

   localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

   localparam logic [CW-1:0]    PERIOD_C  = CW'(PERIOD);
   localparam logic [CW-1:0]    LAST_CNT  = CW'(PERIOD - 1);
   localparam logic [CW:0]      PERIOD_W  = (CW+1)'(PERIOD);
   localparam logic [CW:0]      STEP_W    = (CW+1)'(STEP_SIZE);
   localparam logic [HW-1:0]    HOLD_LAST = HW'((HOLD_PERIODS > 0) ? HOLD_PERIODS - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_LEDS - 1);

   // One extra bit keeps the sum from wrapping before the clamp.
   function automatic logic [CW-1:0] ramp_up(input logic [CW-1:0] cur);
      logic [CW:0] sum;
      sum = {1'b0, cur} + STEP_W;
      return (sum >= PERIOD_W) ? PERIOD_C : sum[CW-1:0];
   endfunction

   function automatic logic [CW-1:0] ramp_down(input logic [CW-1:0] cur);
      logic signed [CW+1:0] diff;
      diff = $signed({2'b00, cur}) - $signed({1'b0, STEP_W});
      return diff[CW+1] ? '0 : diff[CW-1:0];
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur,
                                                  input logic             rev);
      if (rev) begin
         return (cur == '0) ? IDX_LAST : cur - 1'b1;
      end
      return (cur == IDX_LAST) ? '0 : cur + 1'b1;
   endfunction

   state_t              state_q, state_d;
   logic [CW-1:0]       counter_q, counter_d;
   logic [CW-1:0]       ccr_q, ccr_d;
   logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_LEDS-1:0] leds_q, leds_d;
   logic                tick;
   logic [CW-1:0]       ccr_up, ccr_dn;

   assign tick   = (state_q != IDLE) && (counter_q == LAST_CNT);
   assign ccr_up = ramp_up(ccr_q);
   assign ccr_dn = ramp_down(ccr_q);

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      ccr_d      = ccr_q;
      hold_cnt_d = hold_cnt_q;
      idx_d      = idx_q;
      leds_d     = '0;

      // Disable outranks everything, including a pending advance.
      if (!en) begin
         state_d    = IDLE;
         counter_d  = '0;
         ccr_d      = '0;
         hold_cnt_d = '0;
      end else if (state_q == IDLE) begin
         state_d    = RISE;
         counter_d  = '0;
         ccr_d      = '0;
         hold_cnt_d = '0;
      end else begin
         leds_d[idx_q] = (counter_q < ccr_q);
         counter_d     = tick ? '0 : counter_q + 1'b1;
         if (tick) begin
            unique case (state_q)
               RISE: begin
                  ccr_d = ccr_up;
                  if (ccr_up == PERIOD_C) begin
                     hold_cnt_d = '0;
                     state_d    = (HOLD_PERIODS > 0) ? HOLD : FALL;
                  end
               end
               HOLD: begin
                  if (hold_cnt_q == HOLD_LAST) begin
                     state_d = FALL;
                  end else begin
                     hold_cnt_d = hold_cnt_q + 1'b1;
                  end
               end
               FALL: begin
                  ccr_d = ccr_dn;
                  if (ccr_dn == '0) begin
                     state_d = RISE;
                     idx_d   = next_idx(idx_q, reverse);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         ccr_q      <= '0;
         hold_cnt_q <= '0;
         idx_q      <= '0;
         leds_q     <= '0;
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         ccr_q      <= ccr_d;
         hold_cnt_q <= hold_cnt_d;
         idx_q      <= idx_d;
         leds_q     <= leds_d;
      end
   end

   assign leds        = leds_q;
   assign active_idx  = idx_q;
   assign state       = state_q;
   assign period_tick = tick;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer: main instance plus HOLD_PERIODS=0 and STEP_SIZE=10 variants.
module tb_led_fade_sequencer;

   logic       clk;
   logic       rst;
   logic       en;
   logic       reverse;

   logic [3:0] leds_m, leds_h, leds_s;
   logic [1:0] idx_m, idx_h, idx_s;
   logic [1:0] state_m, state_h, state_s;
   logic       tick_m, tick_h, tick_s;

   int n_checks = 0;
   int n_pass   = 0;
   int onehot_err = 0;

   int q_m[$];
   int q_h[$];
   int q_s[$];

   led_fade_sequencer #(.NUM_LEDS(4), .IDX_W(2), .CW(8), .PERIOD(10), .STEP_SIZE(4),
                        .HOLD_PERIODS(2)) dut_m (
      .clk(clk), .rst(rst), .en(en), .reverse(reverse),
      .leds(leds_m), .active_idx(idx_m), .state(state_m), .period_tick(tick_m));

   led_fade_sequencer #(.NUM_LEDS(4), .IDX_W(2), .CW(8), .PERIOD(10), .STEP_SIZE(4),
                        .HOLD_PERIODS(0)) dut_h (
      .clk(clk), .rst(rst), .en(en), .reverse(reverse),
      .leds(leds_h), .active_idx(idx_h), .state(state_h), .period_tick(tick_h));

   led_fade_sequencer #(.NUM_LEDS(4), .IDX_W(2), .CW(8), .PERIOD(10), .STEP_SIZE(10),
                        .HOLD_PERIODS(2)) dut_s (
      .clk(clk), .rst(rst), .en(en), .reverse(reverse),
      .leds(leds_s), .active_idx(idx_s), .state(state_s), .period_tick(tick_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one clock and sample just after the edge; LEDs must be one-hot or zero
   // and may only be lit on the LED that currently owns the engine.
   task automatic step();
      @(posedge clk);
      #1;
      if (($countones(leds_m) > 1) || ((leds_m & ~(4'b0001 << idx_m)) != 4'b0000))
         onehot_err++;
   endtask

   task automatic expect_advance(input logic [1:0] from_i, input logic [1:0] to_i);
      repeat (79) step();
      check("adv_before", {30'd0, idx_m}, {30'd0, from_i});
      step();
      check("adv_after", {30'd0, idx_m}, {30'd0, to_i});
   endtask

   initial begin
      int cnt_m, cnt_h, cnt_s;
      int ticks_m, ticks_h, ticks_s;
      int exp_v;
      logic [2:0] hi_m, hi_h, hi_s;
      logic h_hold;

      rst = 1'b1;
      en = 1'b1;
      reverse = 1'b0;

      // Reset held three cycles with en already high.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_leds",  {28'd0, leds_m},  32'd0);
         check("rst_state", {30'd0, state_m}, 32'd0);
         check("rst_idx",   {30'd0, idx_m},   32'd0);
         check("rst_tick",  {31'd0, tick_m},  32'd0);
      end
      rst = 1'b0;
      step();
      check("start_state", {30'd0, state_m}, 32'd1);

      // Single envelope on all three instances.
      q_m = '{0, 4, 8, 10, 10, 10, 6, 2};
      q_h = '{0, 4, 8, 10, 6, 2};
      q_s = '{0, 10, 10, 10};
      cnt_m = 0; cnt_h = 0; cnt_s = 0;
      ticks_m = 0; ticks_h = 0; ticks_s = 0;
      hi_m = '0; hi_h = '0; hi_s = '0;
      h_hold = 1'b0;
      for (int i = 0; i < 80; i++) begin
         step();
         cnt_m += int'(leds_m[0]);
         hi_m |= leds_m[3:1];
         ticks_m += int'(tick_m);
         if (state_h == 2'd2) h_hold = 1'b1;
         if (i < 60) begin
            cnt_h += int'(leds_h[0]);
            hi_h |= leds_h[3:1];
            ticks_h += int'(tick_h);
         end
         if (i < 40) begin
            cnt_s += int'(leds_s[0]);
            hi_s |= leds_s[3:1];
            ticks_s += int'(tick_s);
         end
         if (i % 10 == 9) begin
            exp_v = q_m.pop_front();
            check("env_main", cnt_m, exp_v);
            cnt_m = 0;
            if (i < 60) begin
               exp_v = q_h.pop_front();
               check("env_hold0", cnt_h, exp_v);
               cnt_h = 0;
            end
            if (i < 40) begin
               exp_v = q_s.pop_front();
               check("env_step10", cnt_s, exp_v);
               cnt_s = 0;
            end
         end
         if (i == 9)  check("step10_hold", {30'd0, state_s}, 32'd2);
         if (i == 38) check("step10_idx_pre",  {30'd0, idx_s}, 32'd0);
         if (i == 39) check("step10_idx_post", {30'd0, idx_s}, 32'd1);
         if (i == 58) check("hold0_idx_pre",   {30'd0, idx_h}, 32'd0);
         if (i == 59) check("hold0_idx_post",  {30'd0, idx_h}, 32'd1);
      end
      check("env_idx_next", {30'd0, idx_m}, 32'd1);
      check("env_others_dark", {29'd0, hi_m}, 32'd0);
      check("hold0_others_dark", {29'd0, hi_h}, 32'd0);
      check("step10_others_dark", {29'd0, hi_s}, 32'd0);
      check("tick_count_main", ticks_m, 8);
      check("tick_count_hold0", ticks_h, 6);
      check("tick_count_step10", ticks_s, 4);
      check("hold0_no_hold", {31'd0, h_hold}, 32'd0);

      // Forward wrap 1 -> 2 -> 3 -> 0.
      expect_advance(2'd1, 2'd2);
      expect_advance(2'd2, 2'd3);
      expect_advance(2'd3, 2'd0);

      // Reverse sequence from reset.
      rst = 1'b1;
      reverse = 1'b1;
      step();
      check("rev_rst_state", {30'd0, state_m}, 32'd0);
      rst = 1'b0;
      step();
      check("rev_start", {30'd0, state_m}, 32'd1);
      expect_advance(2'd0, 2'd3);
      expect_advance(2'd3, 2'd2);
      expect_advance(2'd2, 2'd1);
      expect_advance(2'd1, 2'd0);

      // A brief reverse glitch during FALL that clears before the advance is ignored.
      repeat (55) step();
      check("glitch_in_fall", {30'd0, state_m}, 32'd3);
      reverse = 1'b0;
      repeat (15) step();
      reverse = 1'b1;
      repeat (9) step();
      check("glitch_before", {30'd0, idx_m}, 32'd0);
      step();
      check("glitch_after", {30'd0, idx_m}, 32'd3);

      // Direction flipped mid-FALL takes effect only at the advance.
      repeat (55) step();
      check("flip_in_fall", {30'd0, state_m}, 32'd3);
      reverse = 1'b0;
      repeat (24) step();
      check("flip_before", {30'd0, idx_m}, 32'd3);
      step();
      check("flip_after", {30'd0, idx_m}, 32'd0);

      // Disable during the second HOLD period of LED 2.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      expect_advance(2'd0, 2'd1);
      expect_advance(2'd1, 2'd2);
      repeat (45) step();
      check("hold2_state", {30'd0, state_m}, 32'd2);
      en = 1'b0;
      step();
      check("dis_state", {30'd0, state_m}, 32'd0);
      check("dis_leds",  {28'd0, leds_m},  32'd0);
      check("dis_idx",   {30'd0, idx_m},   32'd2);
      check("dis_tick",  {31'd0, tick_m},  32'd0);
      en = 1'b1;
      step();
      check("reen_state", {30'd0, state_m}, 32'd1);
      q_m.push_back(0);
      q_m.push_back(4);
      cnt_m = 0;
      hi_m = '0;
      for (int i = 0; i < 20; i++) begin
         step();
         cnt_m += int'(leds_m[2]);
         hi_m |= {leds_m[3], leds_m[1], leds_m[0]};
         if (i % 10 == 9) begin
            exp_v = q_m.pop_front();
            check("reen_env", cnt_m, exp_v);
            cnt_m = 0;
         end
      end
      check("reen_others_dark", {29'd0, hi_m}, 32'd0);
      check("reen_idx", {30'd0, idx_m}, 32'd2);

      // Reset mid-operation returns ownership to LED 0.
      rst = 1'b1;
      step();
      check("midrst_state", {30'd0, state_m}, 32'd0);
      check("midrst_idx",   {30'd0, idx_m},   32'd0);
      check("midrst_leds",  {28'd0, leds_m},  32'd0);
      rst = 1'b0;
      step();

      // en dropped on the very cycle of the advance tick: no advance.
      repeat (79) step();
      check("last_tick", {31'd0, tick_m}, 32'd1);
      check("last_fall", {30'd0, state_m}, 32'd3);
      en = 1'b0;
      step();
      check("race_idx",   {30'd0, idx_m},   32'd0);
      check("race_state", {30'd0, state_m}, 32'd0);
      en = 1'b1;
      step();
      check("race_reen", {30'd0, state_m}, 32'd1);

      check("onehot_always", onehot_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/led_fade_sequencer.md
Name: led_fade_sequencer

Overview:
- Scheduler for a single shared PWM fade engine across NUM_LEDS LED outputs.
- One period counter and one duty register (ccr) are time-shared: only one LED, selected by active_idx, is driven at a time.
- That LED ramps up, holds at full brightness, ramps down, then the sequencer advances to the next LED (forward or reverse).
- Sits between the board clock and the LED pins; replaces per-LED free-running pulse generators.

Parameters:
- NUM_LEDS, 8, number of LED outputs; 2..2**IDX_W.
- IDX_W, 3, width of active_idx.
- CW, 29, width of the counter and ccr; PERIOD < 2**CW.
- PERIOD, 500000, clocks per PWM period.
- STEP_SIZE, 20000, ccr change per period during ramps; 1..PERIOD.
- HOLD_PERIODS, 10, full-on periods between ramps; 0 is legal.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset; priority over all other inputs.
- en  in  1  run enable, level-sensitive.
- reverse  in  1  sequence direction; 0 = idx+1, 1 = idx-1.
- leds  out  NUM_LEDS  registered LED drive.
- active_idx  out  IDX_W  LED currently owned by the engine.
- state  out  2  IDLE=0, RISE=1, HOLD=2, FALL=3.
- period_tick  out  1  high for one cycle when counter==PERIOD-1 and state!=IDLE.

Behaviour:
- Reset: state=IDLE, counter=0, ccr=0, hold_cnt=0, active_idx=0, leds=0.
- Counter:
  - Runs only in RISE, HOLD and FALL.
  - counter==PERIOD-1 → counter=0 and period_tick=1 that cycle; otherwise +1.
  - In IDLE, counter is held at 0.
- leds (registered, 1-cycle latency):
  - leds[active_idx] <= (counter < ccr); all other bits <= 0.
  - In IDLE, all bits <= 0.
- All ccr, hold_cnt, state and idx updates below occur only on a cycle with period_tick=1, unless stated otherwise.
- IDLE:
  - en=1 → RISE next cycle, with ccr=0 and counter=0.
  - active_idx is unchanged on entry.
- RISE:
  - ccr_n = min(ccr+STEP_SIZE, PERIOD); sum computed at CW+1 bits, no wrap.
  - ccr_n==PERIOD → HOLD with hold_cnt=0 if HOLD_PERIODS>0; otherwise → FALL.
- HOLD:
  - ccr stays at PERIOD, so the LED is fully on.
  - hold_cnt==HOLD_PERIODS-1 → FALL with ccr unchanged; otherwise hold_cnt+1.
  - HOLD therefore lasts exactly HOLD_PERIODS periods.
- FALL:
  - ccr_n = max(ccr-STEP_SIZE, 0); computed signed, no underflow.
  - ccr_n==0 → advance active_idx and → RISE with ccr=0.
- Advance rule:
  - reverse is sampled only on the advance cycle.
  - Forward: NUM_LEDS-1 wraps to 0. Reverse: 0 wraps to NUM_LEDS-1.
- Per-LED envelope (ccr per period): ramp values 0, S, 2S, ... below PERIOD, then PERIOD for (1+HOLD_PERIODS) periods, then down-ramp values above 0.
- en=0 in any non-IDLE state:
  - Next cycle: state=IDLE, counter=0, ccr=0, hold_cnt=0, leds=0.
  - active_idx is retained.
  - Re-enable restarts RISE from ccr=0 on the same LED.
- rst mid-operation: all regs return to reset values next cycle; active_idx=0.
- Simultaneous en=0 and advance tick: en=0 wins; active_idx is not advanced.

Test Plan (NUM_LEDS=4, IDX_W=2, PERIOD=10, STEP_SIZE=4, HOLD_PERIODS=2 unless noted):
- Reset: rst=1 for 3 cycles with en=1 → leds=0, state=0, active_idx=0, period_tick=0; first en cycle after release → state=1 next cycle.
- Single envelope: en=1 from reset; count leds[0] high cycles in each 10-cycle window (offset 1 for latency) → 0,4,8,10,10,10,6,2. Then active_idx=1; leds[3:1] stay 0 throughout the 80 cycles.
- Forward wrap: en=1, reverse=0, run 320+ cycles → active_idx goes 0,1,2,3,0, each held 80 cycles; exactly one-hot or zero leds at all times.
- Reverse: reverse=1 from reset → active_idx goes 0,3,2,1,0. Toggle reverse mid-FALL → direction changes only at the next advance.
- Disable mid-HOLD: drop en during the second HOLD period of idx 2 → next cycle state=0, leds=0, active_idx=2. Re-assert en → first window duty 0, second window 4, on leds[2].
- Edge parameters:
  - HOLD_PERIODS=0 → envelope 0,4,8,10,6,2 (60 cycles per LED), HOLD never entered.
  - STEP_SIZE=10 → envelope 0,10,10,10 (40 cycles per LED).
